pwm_tone_engine: RTL and testbench

Parametrised PWM tone generator driven by the keypad scanner's locked 4-bit key code. It adds octave shifting and saturating duty/octave step controls, and switches note, duty and octave glitch-free only at PWM period boundaries. It sits between the keypad scanner / button debouncers and the speaker pin, and exports the duty level for the seven-segment display.

---
 rtl/pwm_tone_engine.sv | 128 ++++++++++++
 tb/tb_pwm_tone_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_tone_engine.sv
// PWM tone generator: key code selects a note period, octave shifts it down,
// duty sets the high time. Note/duty/octave changes are latched only at period boundaries.
module pwm_tone_engine #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DUTY_MAX  = 10,
  parameter int DUTY_INIT = 5,
  parameter int OCT_MAX   = 3,
  parameter int DUTY_W    = 7
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        key_pad,
  input  logic              duty_up,
  input  logic              duty_down,
  input  logic              oct_up,
  input  logic              oct_down,
  output logic              tone_clk,
  output logic [DUTY_W-1:0] duty_level,
  output logic [1:0]        octave,
  output logic              note_active
);

  localparam int BASE_MAX = CLK_HZ / 262;
  localparam int CNT_W    = $clog2(BASE_MAX + 1);
  localparam int PROD_W   = CNT_W + DUTY_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   p_q, p_d, h_q, h_d;
  logic               tone_d;
  logic [DUTY_W-1:0]  duty_q;
  logic [1:0]         oct_q;
  logic [CNT_W-1:0]   base_sel, p_new, h_new;
  logic [PROD_W-1:0]  prod;
  logic               key_ok, boundary;

  always_comb begin
    case (key_pad[2:0])
      3'd0:    base_sel = CNT_W'(CLK_HZ / 262);
      3'd1:    base_sel = CNT_W'(CLK_HZ / 294);
      3'd2:    base_sel = CNT_W'(CLK_HZ / 330);
      3'd3:    base_sel = CNT_W'(CLK_HZ / 349);
      3'd4:    base_sel = CNT_W'(CLK_HZ / 392);
      3'd5:    base_sel = CNT_W'(CLK_HZ / 440);
      3'd6:    base_sel = CNT_W'(CLK_HZ / 494);
      default: base_sel = CNT_W'(CLK_HZ / 523);
    endcase
  end

  // Latch candidates always use the registered duty/octave, never the pulse in flight.
  assign p_new    = base_sel >> oct_q;
  assign prod     = PROD_W'(p_new) * PROD_W'(duty_q);
  assign h_new    = CNT_W'(prod / PROD_W'(DUTY_MAX));
  assign key_ok   = ~key_pad[3];
  assign boundary = (cnt_q == p_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    h_d     = h_q;
    tone_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (key_ok) begin
          state_d = RUN;
          p_d     = p_new;
          h_d     = h_new;
        end
      end
      RUN: begin
        tone_d = (cnt_q < h_q);
        if (boundary) begin
          cnt_d = '0;
          if (key_ok) begin
            p_d = p_new;
            h_d = h_new;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      h_q      <= '0;
      tone_clk <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      h_q      <= h_d;
      tone_clk <= tone_d;
    end
  end

  // Saturating step controls; opposing pulses in the same cycle cancel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duty_q <= DUTY_W'(DUTY_INIT);
      oct_q  <= '0;
    end else begin
      if (duty_up && !duty_down && duty_q < DUTY_W'(DUTY_MAX))
        duty_q <= duty_q + DUTY_W'(1);
      else if (duty_down && !duty_up && duty_q != '0)
        duty_q <= duty_q - DUTY_W'(1);
      if (oct_up && !oct_down && oct_q < 2'(OCT_MAX))
        oct_q <= oct_q + 2'd1;
      else if (oct_down && !oct_up && oct_q != 2'd0)
        oct_q <= oct_q - 2'd1;
    end
  end

  assign duty_level  = duty_q;
  assign octave      = oct_q;
  assign note_active = (state_q == RUN);

endmodule

// File: tb/tb_pwm_tone_engine.sv
// Scoreboard bench for pwm_tone_engine: a waveform-queue reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_pwm_tone_engine;
  localparam int CLK_HZ    = 26200;
  localparam int DUTY_MAX  = 10;
  localparam int DUTY_INIT = 5;
  localparam int OCT_MAX   = 3;
  localparam int DUTY_W    = 7;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [3:0]        key_pad = 4'hF;
  logic              duty_up = 1'b0, duty_down = 1'b0, oct_up = 1'b0, oct_down = 1'b0;
  logic              tone_clk, note_active;
  logic [DUTY_W-1:0] duty_level;
  logic [1:0]        octave;

  pwm_tone_engine #(
    .CLK_HZ(CLK_HZ), .DUTY_MAX(DUTY_MAX), .DUTY_INIT(DUTY_INIT),
    .OCT_MAX(OCT_MAX), .DUTY_W(DUTY_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_pad(key_pad),
    .duty_up(duty_up), .duty_down(duty_down), .oct_up(oct_up), .oct_down(oct_down),
    .tone_clk(tone_clk), .duty_level(duty_level), .octave(octave), .note_active(note_active)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic              tone;
    logic              act;
    logic [DUTY_W-1:0] duty;
    logic [1:0]        oct;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: a period is a list of tone samples, consumed one per cycle
  int m_duty, m_oct;
  bit m_run;
  bit m_wave[$];

  function automatic int base_of(int k);
    int f[8];
    f = '{262, 294, 330, 349, 392, 440, 494, 523};
    return CLK_HZ / f[k];
  endfunction

  function automatic void model_reset();
    m_duty = DUTY_INIT;
    m_oct  = 0;
    m_run  = 0;
    m_wave.delete();
  endfunction

  function automatic void start_period(int k);
    int p, h;
    p = base_of(k) >> m_oct;
    h = (p * m_duty) / DUTY_MAX;
    for (int i = 0; i < p; i++) m_wave.push_back(i < h);
  endfunction

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, req);
    end
  endtask

  task automatic step(input logic [3:0] k, input bit du, input bit dd, input bit ou, input bit od);
    obs_t e;
    bit   t;
    @(negedge sys_clk);
    key_pad = k; duty_up = du; duty_down = dd; oct_up = ou; oct_down = od;
    @(posedge sys_clk);
    t = 1'b0;
    if (!m_run) begin
      if (k < 8) begin
        m_run = 1;
        start_period(int'(k));
      end
    end else begin
      t = m_wave.pop_front();
      if (m_wave.size() == 0) begin
        if (k < 8) start_period(int'(k));
        else m_run = 0;
      end
    end
    if (du && !dd && m_duty < DUTY_MAX) m_duty++;
    else if (dd && !du && m_duty > 0) m_duty--;
    if (ou && !od && m_oct < OCT_MAX) m_oct++;
    else if (od && !ou && m_oct > 0) m_oct--;
    e.tone = t;
    e.act  = m_run;
    e.duty = DUTY_W'(m_duty);
    e.oct  = 2'(m_oct);
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    repeat (n) step(k, 0, 0, 0, 0);
  endtask

  task automatic pulse(input logic [3:0] k, input bit du, input bit dd, input bit ou, input bit od);
    step(k, du, dd, ou, od);
    step(k, 0, 0, 0, 0);
  endtask

  // monitor
  initial begin
    forever begin
      obs_t e;
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({tone_clk, note_active, duty_level, octave} != e) begin
          n_bad++;
          $display("FAIL cycle t=%0t: got tone=%0b act=%0b duty=%0d oct=%0d expected tone=%0b act=%0b duty=%0d oct=%0d",
                   $time, tone_clk, note_active, duty_level, octave, e.tone, e.act, e.duty, e.oct);
        end
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_tone", int'(tone_clk), 0);
    check("reset_active", int'(note_active), 0);
    check("reset_duty", int'(duty_level), DUTY_INIT);
    check("reset_octave", int'(octave), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // key 0 at duty 5: 50/50 over a 100-cycle period
    hold(4'd0, 250);
    check("duty_init_run", int'(duty_level), 5);

    // key 5, then three duty_up pulses mid-period
    hold(4'd5, 80);
    repeat (3) pulse(4'd5, 1, 0, 0, 0);
    check("duty_after_up3", int'(duty_level), 8);
    hold(4'd5, 150);

    // saturate up, hold, saturate down, hold, then cancel check
    repeat (12) pulse(4'd5, 1, 0, 0, 0);
    check("duty_sat_hi", int'(duty_level), DUTY_MAX);
    hold(4'd5, 130);
    repeat (15) pulse(4'd5, 0, 1, 0, 0);
    check("duty_sat_lo", int'(duty_level), 0);
    hold(4'd5, 130);
    repeat (3) pulse(4'd5, 1, 0, 0, 0);
    pulse(4'd5, 1, 1, 0, 0);
    check("duty_both", int'(duty_level), 3);
    hold(4'd5, 70);

    // octave saturation on key 7
    hold(4'd7, 60);
    repeat (5) pulse(4'd7, 0, 0, 1, 0);
    check("oct_sat_hi", int'(octave), OCT_MAX);
    hold(4'd7, 60);
    repeat (4) pulse(4'd7, 0, 0, 0, 1);
    check("oct_sat_lo", int'(octave), 0);
    repeat (2) pulse(4'd7, 1, 0, 0, 0);
    hold(4'd7, 60);

    // key 0, release at cnt 20: period must run to completion
    guard = 0;
    while (!(m_run && m_wave.size() == 80 && base_of(0) == 100) && guard < 400) begin
      step(4'd0, 0, 0, 0, 0);
      guard++;
    end
    check("reach_cnt20", int'(guard < 400), 1);
    hold(4'hF, 100);
    check("released_active", int'(note_active), 0);
    hold(4'hF, 5);

    // async reset in the high phase
    repeat (3) pulse(4'hF, 1, 0, 0, 0);
    guard = 0;
    while (!(m_run && m_wave.size() == 70) && guard < 400) begin
      step(4'd0, 0, 0, 0, 0);
      guard++;
    end
    check("reach_high_phase", int'(guard < 400), 1);
    #2;
    check("pre_reset_tone", int'(tone_clk), int'(exp_q[$].tone));
    check("pre_reset_duty", int'(duty_level), 8);
    exp_q.delete();
    key_pad = 4'hF;
    sys_rst_n = 1'b0;
    #1;
    check("async_tone", int'(tone_clk), 0);
    check("async_duty", int'(duty_level), DUTY_INIT);
    check("async_active", int'(note_active), 0);
    model_reset();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold(4'd0, 210);

    // randomized segments
    for (int s = 0; s < 60; s++) begin
      logic [3:0] k;
      int len;
      k   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      len = $urandom_range(1, 150);
      for (int c = 0; c < len; c++)
        step(k, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end

    @(negedge sys_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
